// File: rtl/larpix_scoreboard_if.sv
// Bus bundle for the LArPix scoreboard: tag/packet inputs plus the status and
// counter outputs. The stimulus side uses master and the scoreboard uses slave.
interface larpix_scoreboard_if #(
  parameter int DEPTH = 16,
  parameter int CNTW  = 16
) ();
  logic                       tag_valid;
  logic [63:0]                setTag;
  logic                       rx_valid;
  logic [63:0]                rx_packet;
  logic [CNTW-1:0]            match_count;
  logic [CNTW-1:0]            mismatch_count;
  logic [CNTW-1:0]            unexpected_count;
  logic [CNTW-1:0]            timeout_count;
  logic [$clog2(DEPTH):0]     fifo_level;
  logic                       overflow;
  logic                       error;

  modport master (
    output tag_valid, setTag, rx_valid, rx_packet,
    input  match_count, mismatch_count, unexpected_count, timeout_count,
           fifo_level, overflow, error
  );

  modport slave (
    input  tag_valid, setTag, rx_valid, rx_packet,
    output match_count, mismatch_count, unexpected_count, timeout_count,
           fifo_level, overflow, error
  );
endinterface

// File: rtl/larpix_scoreboard.sv
// In-order scoreboard: expected {chip, channel} hits are queued in a FIFO and
// each incoming data packet is compared against the head entry. A head entry
// that waits too long is expired as a timeout.
module larpix_scoreboard #(
  parameter int DEPTH   = 16,
  parameter int TIMEOUT = 4096,
  parameter int CNTW    = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  larpix_scoreboard_if.slave bus
);
  localparam int AW   = $clog2(DEPTH);
  localparam int AGEW = $clog2(TIMEOUT) + 1;

  logic [13:0]     mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [AW:0]     level;
  logic [AGEW-1:0] age;
  logic [CNTW-1:0] match_q, mism_q, unexp_q, tmo_q;
  logic            ovf_q, err_q;

  logic        empty, full, data_pkt, hit, timeout_ev, pop, push, drop;
  logic [13:0] head, tag_entry, pkt_entry;
  logic        unused;

  // Only chip/channel of the tag and type/chip/channel of the packet matter.
  assign unused = ^{bus.setTag[63:14], bus.rx_packet[63:16]};

  function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Event decode for this cycle: packet compare, timeout, push/pop/drop.
  always_comb begin
    empty      = (level == '0);
    full       = (level == (AW+1)'(DEPTH));
    data_pkt   = bus.rx_valid && (bus.rx_packet[1:0] == 2'b01);
    head       = mem[rd_ptr];
    tag_entry  = {bus.setTag[7:0], bus.setTag[13:8]};
    pkt_entry  = {bus.rx_packet[9:2], bus.rx_packet[15:10]};
    hit        = (pkt_entry == head);
    // A data packet in the expiry cycle wins over the timeout.
    timeout_ev = !empty && !data_pkt && (age == AGEW'(TIMEOUT - 1));
    pop        = (data_pkt && !empty) || timeout_ev;
    // A full FIFO can still accept a tag when the head leaves this cycle.
    push       = bus.tag_valid && (!full || pop);
    drop       = bus.tag_valid && full && !pop;
  end

  // Entry storage; contents need no reset since level gates every read.
  always_ff @(posedge clk) begin
    if (push && !clear) mem[wr_ptr] <= tag_entry;
  end

  // Pointers, level, age, counters and sticky flags.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level   <= '0;
      age     <= '0;
      match_q <= '0;
      mism_q  <= '0;
      unexp_q <= '0;
      tmo_q   <= '0;
      ovf_q   <= 1'b0;
      err_q   <= 1'b0;
    end else if (clear) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level   <= '0;
      age     <= '0;
      match_q <= '0;
      mism_q  <= '0;
      unexp_q <= '0;
      tmo_q   <= '0;
      ovf_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      level <= level + 1'b1;
      else if (pop && !push) level <= level - 1'b1;
      age <= (pop || empty) ? '0 : age + 1'b1;
      if (data_pkt && empty) unexp_q <= sat_inc(unexp_q);
      if (data_pkt && !empty && hit)  match_q <= sat_inc(match_q);
      if (data_pkt && !empty && !hit) mism_q  <= sat_inc(mism_q);
      if (timeout_ev) tmo_q <= sat_inc(tmo_q);
      if (drop) ovf_q <= 1'b1;
      if (drop || timeout_ev || (data_pkt && (empty || !hit))) err_q <= 1'b1;
    end
  end

  assign bus.match_count      = match_q;
  assign bus.mismatch_count   = mism_q;
  assign bus.unexpected_count = unexp_q;
  assign bus.timeout_count    = tmo_q;
  assign bus.fifo_level       = level;
  assign bus.overflow         = ovf_q;
  assign bus.error            = err_q;
endmodule

// File: tb/tb_larpix_scoreboard.sv
// Directed and randomized bench for larpix_scoreboard with a queue-based model.
module tb_larpix_scoreboard;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 8;
  localparam int CNTW    = 4;
  localparam int CMAX    = (1 << CNTW) - 1;

  logic clk = 1'b0;
  logic reset_n;
  logic clear;

  larpix_scoreboard_if #(.DEPTH(DEPTH), .CNTW(CNTW)) bus ();

  larpix_scoreboard #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT), .CNTW(CNTW)) dut (
    .clk(clk), .reset_n(reset_n), .clear(clear), .bus(bus)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  // Reference model: expected hits as a queue of {chip, channel}.
  logic [13:0] q [$];
  int m_match, m_mism, m_unexp, m_tmo, m_wait;
  bit m_ovf, m_err;

  function automatic int sat(input int v);
    return (v >= CMAX) ? CMAX : v + 1;
  endfunction

  task automatic model_reset();
    q.delete();
    m_match = 0; m_mism = 0; m_unexp = 0; m_tmo = 0; m_wait = 0;
    m_ovf = 0; m_err = 0;
  endtask

  task automatic model_step(input bit tv, input logic [7:0] tc, input logic [5:0] tch,
                            input bit rv, input logic [1:0] typ,
                            input logic [7:0] pc, input logic [5:0] pch, input bit clr);
    bit was_empty, popped;
    if (clr) begin
      model_reset();
      return;
    end
    was_empty = (q.size() == 0);
    popped = 0;
    if (rv && typ == 2'b01) begin
      if (was_empty) begin
        m_unexp = sat(m_unexp); m_err = 1;
      end else begin
        if (q[0] == {pc, pch}) m_match = sat(m_match);
        else begin m_mism = sat(m_mism); m_err = 1; end
        void'(q.pop_front()); popped = 1;
      end
    end else if (!was_empty && m_wait == TIMEOUT - 1) begin
      m_tmo = sat(m_tmo); m_err = 1;
      void'(q.pop_front()); popped = 1;
    end
    if (tv) begin
      if (q.size() < DEPTH) q.push_back({tc, tch});
      else begin m_ovf = 1; m_err = 1; end
    end
    // Cycles the current head has been waiting.
    m_wait = (popped || was_empty) ? 0 : m_wait + 1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".match"}, 32'(bus.match_count), 32'(m_match));
    chk({tag, ".mism"},  32'(bus.mismatch_count), 32'(m_mism));
    chk({tag, ".unexp"}, 32'(bus.unexpected_count), 32'(m_unexp));
    chk({tag, ".tmo"},   32'(bus.timeout_count), 32'(m_tmo));
    chk({tag, ".level"}, 32'(bus.fifo_level), 32'(q.size()));
    chk({tag, ".ovf"},   32'(bus.overflow), 32'(m_ovf));
    chk({tag, ".err"},   32'(bus.error), 32'(m_err));
  endtask

  task automatic drive_idle();
    bus.tag_valid = 1'b0; bus.rx_valid = 1'b0; clear = 1'b0;
    bus.setTag = '0; bus.rx_packet = '0;
  endtask

  // One clock: apply inputs, step model at the edge, compare 1 time unit later.
  task automatic tick(input string tag, input bit tv, input logic [7:0] tc, input logic [5:0] tch,
                      input bit rv, input logic [1:0] typ,
                      input logic [7:0] pc, input logic [5:0] pch, input bit clr);
    bus.tag_valid = tv;
    bus.setTag    = {32'($urandom()), 18'($urandom()), tch, tc};
    bus.rx_valid  = rv;
    bus.rx_packet = {32'($urandom()), 16'($urandom()), pch, pc, typ};
    clear         = clr;
    @(posedge clk);
    model_step(tv, tc, tch, rv, typ, pc, pch, clr);
    #1;
    chk_all(tag);
    drive_idle();
  endtask

  task automatic push(input string tag, input logic [7:0] c, input logic [5:0] ch);
    tick(tag, 1, c, ch, 0, 2'b00, 8'd0, 6'd0, 0);
  endtask
  task automatic pkt(input string tag, input logic [7:0] c, input logic [5:0] ch);
    tick(tag, 0, 8'd0, 6'd0, 1, 2'b01, c, ch, 0);
  endtask
  task automatic idle(input string tag);
    tick(tag, 0, 8'd0, 6'd0, 0, 2'b00, 8'd0, 6'd0, 0);
  endtask
  task automatic do_clear();
    tick("clear", 1, 8'd3, 6'd5, 1, 2'b01, 8'd1, 6'd1, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    drive_idle();
    model_reset();
    reset_n = 1'b0;
    #12;
    chk_all("reset");
    @(negedge clk); reset_n = 1'b1;

    // Two in-order matches.
    push("r26.p0", 8'd3, 6'd5);
    push("r26.p1", 8'd3, 6'd7);
    pkt("r26.k0", 8'd3, 6'd5);
    pkt("r26.k1", 8'd3, 6'd7);
    chk("r26.match_const", 32'(bus.match_count), 2);
    chk("r26.level_const", 32'(bus.fifo_level), 0);
    chk("r26.err_const", 32'(bus.error), 0);

    // Channel mismatch pops the head and flags error.
    do_clear();
    push("r27.p", 8'd3, 6'd5);
    pkt("r27.k", 8'd3, 6'd6);
    chk("r27.mism_const", 32'(bus.mismatch_count), 1);
    chk("r27.err_const", 32'(bus.error), 1);

    // Packet on empty FIFO, then a non-data packet that must be ignored.
    do_clear();
    pkt("r28.k", 8'd9, 6'd9);
    chk("r28.unexp_const", 32'(bus.unexpected_count), 1);
    tick("r28.type2", 0, 8'd0, 6'd0, 1, 2'b10, 8'd9, 6'd9, 0);
    chk("r28.unexp_hold", 32'(bus.unexpected_count), 1);

    // Push and packet in the same cycle on an empty FIFO: unexpected.
    do_clear();
    tick("r19.both", 1, 8'd4, 6'd2, 1, 2'b01, 8'd4, 6'd2, 0);
    chk("r19.level_const", 32'(bus.fifo_level), 1);
    pkt("r19.k", 8'd4, 6'd2);
    chk("r19.match_const", 32'(bus.match_count), 1);

    // Timeout exactly TIMEOUT cycles after the entry becomes head.
    do_clear();
    push("r29.p", 8'd3, 6'd5);
    for (int i = 0; i < TIMEOUT - 1; i++) idle("r29.wait");
    chk("r29.tmo_before", 32'(bus.timeout_count), 0);
    idle("r29.expire");
    chk("r29.tmo_const", 32'(bus.timeout_count), 1);
    chk("r29.level_const", 32'(bus.fifo_level), 0);

    // Packet in the expiry cycle wins.
    do_clear();
    push("r29b.p", 8'd3, 6'd5);
    for (int i = 0; i < TIMEOUT - 1; i++) idle("r29b.wait");
    pkt("r29b.k", 8'd3, 6'd5);
    chk("r29b.match_const", 32'(bus.match_count), 1);
    chk("r29b.tmo_const", 32'(bus.timeout_count), 0);

    // Full FIFO: push with concurrent pop is accepted, bare push overflows.
    do_clear();
    for (int i = 0; i < DEPTH; i++) push("r30.fill", 8'(i + 1), 6'(i));
    tick("r30.push_pop", 1, 8'd7, 6'd7, 1, 2'b01, 8'd1, 6'd0, 0);
    chk("r30.level_pp", 32'(bus.fifo_level), 4);
    chk("r30.ovf_pp", 32'(bus.overflow), 0);
    push("r30.over", 8'd8, 6'd8);
    chk("r30.level_const", 32'(bus.fifo_level), 4);
    chk("r30.ovf_const", 32'(bus.overflow), 1);
    // Drain in order.
    pkt("r30.d1", 8'd2, 6'd1);
    pkt("r30.d2", 8'd3, 6'd2);
    pkt("r30.d3", 8'd4, 6'd3);
    pkt("r30.d4", 8'd7, 6'd7);

    // Counter saturation.
    do_clear();
    for (int i = 0; i < CMAX + 2; i++) begin
      push("r31.p", 8'd5, 6'd1);
      pkt("r31.k", 8'd5, 6'd1);
    end
    chk("r31.sat_const", 32'(bus.match_count), CMAX);

    // Randomized traffic with occasional clears.
    do_clear();
    for (int i = 0; i < 600; i++) begin
      bit tv, rv, clr;
      logic [1:0] typ;
      logic [7:0] tc, pc;
      logic [5:0] tch, pch;
      tv  = ($urandom_range(0, 99) < 50);
      rv  = ($urandom_range(0, 99) < 35);
      clr = ($urandom_range(0, 99) < 2);
      typ = ($urandom_range(0, 99) < 70) ? 2'b01 : 2'($urandom());
      tc  = 8'($urandom_range(3, 4));
      tch = 6'($urandom_range(5, 6));
      if (q.size() != 0 && $urandom_range(0, 99) < 75) begin
        pc = q[0][13:6]; pch = q[0][5:0];
      end else begin
        pc = 8'($urandom_range(3, 4)); pch = 6'($urandom_range(5, 6));
      end
      tick("rand", tv, tc, tch, rv, typ, pc, pch, clr);
    end

    // Asynchronous reset mid-stream.
    push("r25.p0", 8'd3, 6'd5);
    push("r25.p1", 8'd3, 6'd6);
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    chk_all("r25.in_reset");
    @(negedge clk); @(negedge clk);
    reset_n = 1'b1;
    push("r25.after", 8'd3, 6'd5);
    chk("r25.level_const", 32'(bus.fifo_level), 1);
    pkt("r25.k", 8'd3, 6'd5);
    chk("r25.match_const", 32'(bus.match_count), 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/larpix_scoreboard.md
LARPIX_SCOREBOARD -- requirements
Module: larpix_scoreboard

Interface
REQ-001 Parameter DEPTH, default 16: number of expected-hit entries; power of two, at least 2.
REQ-002 Parameter TIMEOUT, default 4096: maximum clk cycles a head entry may wait for its packet.
REQ-003 Parameter CNTW, default 16: width of each event counter.
REQ-004 The block SHALL use one clock and an asynchronous, active-low reset; the clock is clk and the reset is reset_n.
REQ-005 Ports (name / direction / width / meaning):
- clk / in / 1 / clock.
- reset_n / in / 1 / asynchronous active-low reset.
- clear / in / 1 / synchronous flush of the FIFO, all counters and all flags.
- tag_valid / in / 1 / setTag is valid this cycle.
- setTag / in / 64 / expected hit from stimulus; [7:0] chip id, [13:8] channel, [63:14] ignored.
- rx_valid / in / 1 / rx_packet is valid this cycle.
- rx_packet / in / 64 / packet from chip; [1:0] type, [9:2] chip id, [15:10] channel.
- match_count / out / CNTW / packets that matched the head entry.
- mismatch_count / out / CNTW / packets that did not match the head entry.
- unexpected_count / out / CNTW / data packets received while the FIFO was empty.
- timeout_count / out / CNTW / head entries expired without a packet.
- fifo_level / out / log2(DEPTH)+1 / number of entries held.
- overflow / out / 1 / sticky; a tag was dropped because the FIFO was full.
- error / out / 1 / sticky; OR of mismatch, unexpected, timeout and overflow events.

Function
REQ-006 Each expected entry SHALL be {chip[7:0], channel[5:0]} captured from setTag; entries are held in a DEPTH-deep FIFO in order.
REQ-007 A data packet is rx_valid=1 with rx_packet[1:0]=2'b01; all other packet types SHALL be ignored with no state change.
REQ-008 Matching is in-order against the head entry only; the compare is registered, so its effect appears one clk cycle after the packet.
REQ-009 Data packet with FIFO non-empty, chip and channel equal to head: pop head, match_count+1.
REQ-010 Data packet with FIFO non-empty, chip or channel unequal to head: pop head, mismatch_count+1, error set.
REQ-011 Data packet with FIFO empty: unexpected_count+1, error set, FIFO unchanged.
REQ-012 Age counter: resets to 0 on every pop and whenever the FIFO is empty; increments once per cycle while the FIFO is non-empty.
REQ-013 Timeout: when age reaches TIMEOUT-1 with no data packet that cycle, pop head, timeout_count+1, error set.
REQ-014 A data packet in the timeout cycle SHALL take priority; no timeout is counted.
REQ-015 tag_valid with FIFO not full: push the entry.
REQ-016 tag_valid with FIFO full and no pop this cycle: drop the tag, set overflow and error.
REQ-017 tag_valid with FIFO full and a pop this cycle: accept the push; level unchanged.
REQ-018 Simultaneous push and pop on a non-full, non-empty FIFO: level unchanged, order preserved.
REQ-019 Push into an empty FIFO: the entry becomes head next cycle; a packet in the same cycle as that push counts as unexpected.
REQ-020 Counters SHALL saturate at 2^CNTW-1 and never wrap.
REQ-021 Read and write pointers SHALL wrap modulo DEPTH.
REQ-022 fifo_level SHALL equal pushes minus pops since the last reset or clear.
REQ-023 clear SHALL take priority over every concurrent push, packet or timeout event in the same cycle.

Reset
REQ-024 While reset_n=0, or in the cycle after clear=1: all counters 0, fifo_level 0, overflow 0, error 0, pointers 0, age 0.
REQ-025 Reset asserted mid-operation SHALL discard all entries with no counter update; the first push after deassertion is accepted normally.

Verification
REQ-026 Push tags (chip 3, ch 5), (3, 7); send data packets for chip 3 ch 5 then ch 7 -> match_count=2, fifo_level=0, error=0.
REQ-027 Push (3, 5); send packet (3, 6) -> mismatch_count=1, error=1, fifo_level=0.
REQ-028 Send a data packet with the FIFO empty -> unexpected_count=1; then send a type 2'b10 packet -> no change.
REQ-029 TIMEOUT=8, push one tag, send no packet -> timeout_count=1 exactly 8 cycles after the entry becomes head; a packet on cycle 8 instead gives match_count=1, timeout_count=0.
REQ-030 DEPTH=4: push 5 tags back-to-back -> fifo_level=4, overflow=1; push a tag while a match pops -> level stays 4, no new overflow.
REQ-031 Force match_count to 2^CNTW-1, then match once more -> match_count holds; assert reset_n=0 mid-stream -> all outputs 0.
